xbar_sched: RTL and testbench

- Round-robin scheduler that shares one crossbar tile between NREQ requesters.
- Accepts one input vector at a time from a requester and issues it to the crossbar through a toggle-valid / toggle-ready handshake.
- Routes the crossbar result back to the granted requester over valid/ready.
- Sits inside the tile, between the per-channel input buffers and the xbar instance.

---
 rtl/xbar_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/xbar_sched.sv | 151 +++++++++++++++
 tb/tb_xbar_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types for the crossbar scheduler: FSM states and vector shapes.
// Vector widths default here and may be overridden on the command line.
`ifndef QW
`define QW 32
`endif
`ifndef XH
`define XH 4
`endif
`ifndef XW
`define XW 4
`endif

package xbar_pkg;

  localparam int unsigned QW = `QW;
  localparam int unsigned XH = `XH;
  localparam int unsigned XW = `XW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_XBAR,
    RESP,
    ACK
  } sched_state_t;

  // One crossbar input vector (XH elements) and one result vector (XW elements).
  typedef logic [XH-1:0][QW-1:0] vec_in_t;
  typedef logic [XW-1:0][QW-1:0] vec_out_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotation: first requester at or above
// ptr_i, wrapping past NREQ-1 back to 0. Shared by several tile resources.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    any_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  int unsigned       cand;
  logic [IdxW-1:0]   cand_idx;

  // Scan from ptr_i upward; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(ptr_i) + k) % NREQ;
      cand_idx = IdxW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        gnt_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/xbar_sched.sv
// Round-robin scheduler sharing one crossbar between NREQ requesters.
// One operation in flight: issue via toggle-valid, collect the result over
// valid/ready, then wait for the crossbar's ready toggle before re-arming.
module xbar_sched
  import xbar_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  vec_in_t [NREQ-1:0]      req_vector_i,
  output vec_out_t                rsp_vector_o,
  output logic [NREQ-1:0]         rsp_valid_o,
  input  logic [NREQ-1:0]         rsp_ready_i,
  output vec_in_t                 xbar_vector_o,
  output logic                    xbar_valid_tg_o,
  input  logic                    xbar_ready_tg_i,
  input  vec_out_t                xbar_vector_i,
  input  logic                    xbar_valid_i,
  output logic                    xbar_ready_o,
  output logic [$clog2(NREQ)-1:0] grant_id_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned     IdxW    = $clog2(NREQ);
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

  sched_state_t    state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_id_q, grant_id_d;
  vec_in_t         xbar_vector_q, xbar_vector_d;
  logic            valid_tg_q, valid_tg_d;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
  logic            rdy_s1_q, rdy_s2_q, rdy_s3_q;
  logic            rdy_edge;

  logic [NREQ-1:0] arb_gnt;
  logic [IdxW-1:0] arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // Ready toggle crosses in asynchronously; the third flop only remembers the
  // previous synchronized level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
      rdy_s3_q <= 1'b0;
    end else begin
      rdy_s1_q <= xbar_ready_tg_i;
      rdy_s2_q <= rdy_s1_q;
      rdy_s3_q <= rdy_s2_q;
    end
  end

  assign rdy_edge = rdy_s2_q ^ rdy_s3_q;

  // Next-state, datapath capture and handshake outputs.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    xbar_vector_d = xbar_vector_q;
    valid_tg_d    = valid_tg_q;
    wd_cnt_d      = wd_cnt_q;
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    xbar_ready_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready_o   = arb_gnt;
          xbar_vector_d = req_vector_i[arb_idx];
          valid_tg_d    = ~valid_tg_q;
          grant_id_d    = arb_idx;
          wd_cnt_d      = '0;
          state_d       = WAIT_XBAR;
        end
      end
      WAIT_XBAR: begin
        if (wd_cnt_q != CntMax) wd_cnt_d = wd_cnt_q + 1'b1;
        if (xbar_valid_i) state_d = RESP;
      end
      RESP: begin
        // Requester-side backpressure passes straight through to the crossbar.
        rsp_valid_o[grant_id_q] = xbar_valid_i;
        xbar_ready_o            = rsp_ready_i[grant_id_q];
        if (xbar_valid_i && rsp_ready_i[grant_id_q]) state_d = ACK;
      end
      ACK: begin
        if (wd_cnt_q != CntMax) wd_cnt_d = wd_cnt_q + 1'b1;
        // Re-arm only once the crossbar is idle again, else the next valid
        // toggle could be missed.
        if (rdy_edge) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == LastIdx) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sticky: the operation keeps running, only the flag reports the overrun.
    timeout_d = timeout_q | (wd_cnt_d == CntMax);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      xbar_vector_q <= '0;
      valid_tg_q    <= 1'b0;
      wd_cnt_q      <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      xbar_vector_q <= xbar_vector_d;
      valid_tg_q    <= valid_tg_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign rsp_vector_o    = xbar_vector_i;
  assign xbar_vector_o   = xbar_vector_q;
  assign xbar_valid_tg_o = valid_tg_q;
  assign grant_id_o      = grant_id_q;
  assign busy_o          = (state_q != IDLE);
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_xbar_sched.sv
// Directed bench for xbar_sched with a behavioural crossbar (sum of inputs,
// weights 1.0) and a scoreboard of expected grant/result pairs.
module tb_xbar_sched;
  import xbar_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TO   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  vec_in_t [NREQ-1:0]   req_vector_i;
  vec_out_t             rsp_vector_o;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  vec_in_t              xbar_vector_o;
  logic                 xbar_valid_tg_o;
  logic                 xbar_ready_tg_i;
  vec_out_t             xbar_vector_i;
  logic                 xbar_valid_i;
  logic                 xbar_ready_o;
  logic [1:0]           grant_id_o;
  logic                 busy_o;
  logic                 timeout_o;

  logic model_tg;
  logic spur_tg = 1'b0;
  int   stall_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int       idx;
    vec_out_t vec;
  } exp_t;
  exp_t sb[$];

  assign xbar_ready_tg_i = model_tg ^ spur_tg;

  always #5 clk = ~clk;

  xbar_sched #(
    .NREQ        (NREQ),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_vector_i    (req_vector_i),
    .rsp_vector_o    (rsp_vector_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .xbar_vector_o   (xbar_vector_o),
    .xbar_valid_tg_o (xbar_valid_tg_o),
    .xbar_ready_tg_i (xbar_ready_tg_i),
    .xbar_vector_i   (xbar_vector_i),
    .xbar_valid_i    (xbar_valid_i),
    .xbar_ready_o    (xbar_ready_o),
    .grant_id_o      (grant_id_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  // Single-precision <-> real, exact for the small values used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == '0) d = {f[31], 63'b0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Crossbar with every weight 1.0: each output is the sum of all inputs.
  function automatic vec_out_t xbar_fn(input vec_in_t v);
    real      acc;
    vec_out_t r;
    acc = 0.0;
    for (int i = 0; i < int'(XH); i++) acc = acc + f2r(v[i]);
    for (int j = 0; j < int'(XW); j++) r[j] = r2f(acc);
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Crossbar model: sees the valid toggle, samples two cycles after it, answers
  // after stall_cyc extra cycles, then toggles ready one cycle after handshake.
  typedef enum logic [2:0] {MIdle, MSamp, MLat, MOut, MTog} mstate_t;
  mstate_t m_q;
  logic    seen_q;
  vec_in_t cap_q;
  int      lat_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q           <= MIdle;
      seen_q        <= 1'b0;
      model_tg      <= 1'b0;
      xbar_valid_i  <= 1'b0;
      xbar_vector_i <= '0;
      cap_q         <= '0;
      lat_q         <= 0;
    end else begin
      case (m_q)
        MIdle: if (xbar_valid_tg_o != seen_q) begin
          seen_q <= xbar_valid_tg_o;
          m_q    <= MSamp;
        end
        MSamp: begin
          cap_q <= xbar_vector_o;
          lat_q <= stall_cyc;
          m_q   <= MLat;
        end
        MLat: if (lat_q == 0) begin
          xbar_valid_i  <= 1'b1;
          xbar_vector_i <= xbar_fn(cap_q);
          m_q           <= MOut;
        end else begin
          lat_q <= lat_q - 1;
        end
        MOut: if (xbar_ready_o) begin
          xbar_valid_i  <= 1'b0;
          xbar_vector_i <= '0;
          m_q           <= MTog;
        end
        MTog: begin
          model_tg <= ~model_tg;
          m_q      <= MIdle;
        end
        default: m_q <= MIdle;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present mask at a negedge in IDLE, expect grant exp, push expectation.
  task automatic issue_op(input logic [NREQ-1:0] mask, input int exp, input bit drop);
    logic tg_exp;
    exp_t e;
    tg_exp      = ~xbar_valid_tg_o;
    req_valid_i = mask;
    #1;
    chk("req_ready_onehot", req_ready_o, onehot(exp));
    e.idx = exp;
    e.vec = xbar_fn(req_vector_i[exp]);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (drop) req_valid_i = mask & ~onehot(exp);
    chk("valid_toggle", xbar_valid_tg_o, tg_exp);
    chk("xbar_vector_issued", xbar_vector_o, req_vector_i[exp]);
    chk("grant_id_issue", grant_id_o, exp);
    chk("busy_after_issue", busy_o, 1);
  endtask

  // Follow the operation back to IDLE, comparing the routed result.
  task automatic finish_op(input int exp, input bit pre_got);
    bit   got;
    bit   done;
    int   extra;
    int   ack_cyc;
    exp_t e;
    got     = pre_got;
    done    = 1'b0;
    extra   = 0;
    ack_cyc = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!busy_o) begin
        done = 1'b1;
      end else begin
        if (got) begin
          ack_cyc++;
          chk("ack_rsp_valid_low", rsp_valid_o, 0);
        end
        if (req_ready_o != '0) extra++;
        if (rsp_valid_o != '0 && !got) begin
          got = 1'b1;
          chk("sb_pending", sb.size(), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_valid_onehot", rsp_valid_o, onehot(e.idx));
            chk("rsp_vector", rsp_vector_o, e.vec);
          end
        end
      end
    end
    chk("op_done_in_budget", done, 1);
    chk("rsp_seen", got, 1);
    chk("single_ready_pulse", extra, 0);
    chk("ack_cycles", ack_cyc, 4);
    chk("grant_id_hold", grant_id_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] vals [NREQ];
    logic        tg_save;
    bit          seen;
    exp_t        e;

    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000};
    for (int r = 0; r < int'(NREQ); r++)
      for (int k = 0; k < int'(XH); k++) req_vector_i[r][k] = vals[r];
    req_valid_i = '0;
    rsp_ready_i = '1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_xbar_vector", xbar_vector_o, 0);
    chk("rst_valid_tg", xbar_valid_tg_o, 0);
    chk("rst_xbar_ready", xbar_ready_o, 0);
    chk("rst_grant_id", grant_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // All requesters valid continuously: grants 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      issue_op(4'b1111, k % 4, 1'b0);
      finish_op(k % 4, 1'b0);
    end
    req_valid_i = '0;

    // Single request with all-1.0 vector; pointer wraps from 1 back to 0.
    issue_op(4'b0001, 0, 1'b1);
    finish_op(0, 1'b0);
    chk("single_rsp_is_4p0", xbar_fn(req_vector_i[0]), {4{32'h40800000}});

    // Spurious ready toggle while idle must be ignored.
    tg_save = xbar_valid_tg_o;
    spur_tg = 1'b1;
    repeat (6) @(negedge clk);
    chk("spur_busy", busy_o, 0);
    chk("spur_valid_tg", xbar_valid_tg_o, tg_save);
    chk("spur_req_ready", req_ready_o, 0);
    issue_op(4'b0010, 1, 1'b1);
    finish_op(1, 1'b0);

    // Backpressure on requester 2 for 20 cycles in RESP.
    rsp_ready_i = 4'b1011;
    issue_op(4'b0100, 2, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid_o != '0) seen = 1'b1;
    end
    chk("bp_rsp_seen", seen, 1);
    chk("bp_sb_pending", sb.size(), 1);
    e = sb.pop_front();
    for (int k = 0; k < 20; k++) begin
      chk("bp_rsp_valid", rsp_valid_o, onehot(e.idx));
      chk("bp_rsp_vector", rsp_vector_o, e.vec);
      chk("bp_xbar_ready", xbar_ready_o, 0);
      if (k < 19) @(negedge clk);
    end
    rsp_ready_i = '1;
    #1;
    chk("bp_release_ready", xbar_ready_o, 1);
    finish_op(2, 1'b1);
    chk("bp_no_timeout", timeout_o, 0);

    // Crossbar stall: watchdog fires 16 cycles after issue, op still completes.
    stall_cyc = 30;
    issue_op(4'b1000, 3, 1'b1);
    for (int k = 0; k <= int'(TO); k++) begin
      @(negedge clk);
      chk("wd_timeout", timeout_o, (k >= int'(TO)) ? 1 : 0);
    end
    finish_op(3, 1'b0);
    chk("wd_sticky", timeout_o, 1);
    stall_cyc = 0;

    // Move the pointer to 2, then reset in the middle of an operation.
    issue_op(4'b0010, 1, 1'b1);
    finish_op(1, 1'b0);
    stall_cyc = 30;
    issue_op(4'b1000, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_valid_tg", xbar_valid_tg_o, 0);
    chk("arst_xbar_vector", xbar_vector_o, 0);
    chk("arst_grant_id", grant_id_o, 0);
    chk("arst_timeout", timeout_o, 0);
    chk("arst_rsp_valid", rsp_valid_o, 0);
    chk("arst_xbar_ready", xbar_ready_o, 0);
    sb.delete();
    spur_tg   = 1'b0;
    stall_cyc = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue_op(4'b0101, 0, 1'b1);
    finish_op(0, 1'b0);
    chk("post_rst_timeout", timeout_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
